ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard on the same PS2_CLK/PS2_DAT pair the receiver listens on. It runs the full host-request sequence: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop bit, then device ACK. It drives the lines only as open-drain pull-lows, which the top level turns into tri-state pins. While it is busy it tells the receive path to ignore line activity.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_host_tx_sync.sv | 34 +++
 rtl/ps2_host_tx.sv | 199 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host-side definitions (FSM states, error bit positions,
// common keyboard command bytes). Used by both the transmit and receive paths.
// No logic; types, constants and one parity helper only.
package ps2_pkg;

  // Host transmit FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5,
    ST_DONE      = 3'd6
  } ps2_state_e;

  // Bit positions inside tx_err
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_NOACK   = 1;

  // Common keyboard commands
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Last data-carrying device edge number (d0..d7 on 1..8, parity on 9)
  localparam logic [3:0] LAST_DATA_EDGE = 4'd9;

  // PS/2 uses odd parity: the parity bit makes the 9-bit total odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_sync.sv
// sync: two-flop synchronizer for one asynchronous PS/2 pin.
// Latency: 2 clk cycles from pin to o_q.
// Backpressure: none (free-running sampler).
//
// Ports:
//   i_clk    - system clock
//   i_resetn - synchronous active-low reset; flops load RST_VAL
//   i_d      - asynchronous input pin value
//   o_q      - synchronized value
module sync #(
  parameter logic RST_VAL = 1'b1   // PS/2 lines idle high
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter (inhibit, start, 8 data LSB-first,
// odd parity, stop, device ACK) driving open-drain pull-low enables.
// Latency: request accepted one cycle after i_tx_start in IDLE; device edge -> dat_oe in 3 cycles.
// Backpressure: i_tx_start is only accepted in IDLE; o_tx_busy high means requests are ignored.
//
// Ports:
//   i_clk, i_resetn          - system clock, synchronous active-low reset
//   i_tx_data, i_tx_start    - byte to send and level request (sampled in IDLE only)
//   o_tx_busy, o_rx_inhibit  - high from accept through the done cycle
//   o_tx_done, o_tx_err      - one-cycle completion pulse and its status (bit0 timeout, bit1 no ACK)
//   i_ps2_clk_in/_dat_in     - raw asynchronous pin values
//   o_ps2_clk_oe/_dat_oe     - 1 = pull the pin low, 0 = release
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_start,
  output logic       o_tx_busy,
  output logic       o_tx_done,
  output logic [1:0] o_tx_err,
  output logic       o_rx_inhibit,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_dat_in,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_dat_oe
);

  // One counter serves the inhibit, start and watchdog phases; size it for
  // whichever load is largest (normally the watchdog).
  localparam int CNT_MAX_A = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > START_CYCLES) ? CNT_MAX_A : START_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  // Phase counters load N-1 so the phase lasts exactly N cycles.
  localparam logic [CNT_W-1:0] INH_LOAD   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LOAD    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  ps2_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [8:0]       r_shift;      // {parity, data}, shifted out LSB first
  logic [3:0]       r_bitcnt;     // device falling edges seen in SEND, 0..10
  logic [1:0]       r_err;
  logic             r_clk_oe;
  logic             r_dat_oe;
  logic             r_clk_prev;   // previous synchronized clock for edge detect

  logic w_clk_s;
  logic w_dat_s;
  logic w_fe;
  logic w_cnt_zero;

  sync #(.RST_VAL(1'b1)) u_sync_clk (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_d      (i_ps2_clk_in),
    .o_q      (w_clk_s)
  );

  sync #(.RST_VAL(1'b1)) u_sync_dat (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_d      (i_ps2_dat_in),
    .o_q      (w_dat_s)
  );

  assign w_fe       = r_clk_prev & ~w_clk_s;
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_err      <= '0;
      r_clk_oe   <= 1'b0;
      r_dat_oe   <= 1'b0;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_prev <= w_clk_s;

      case (r_state)
        ST_IDLE: begin
          if (i_tx_start) begin
            r_shift  <= {odd_parity(i_tx_data), i_tx_data};
            r_bitcnt <= '0;
            r_err    <= '0;
            r_cnt    <= INH_LOAD;
            r_clk_oe <= 1'b1;
            r_dat_oe <= 1'b0;
            r_state  <= ST_INHIBIT;
          end
        end

        // Device edges here are our own inhibit pulling the line; ignore them.
        ST_INHIBIT: begin
          if (w_cnt_zero) begin
            r_cnt    <= START_LOAD;
            r_dat_oe <= 1'b1;           // start bit (0) goes out with clock still held
            r_state  <= ST_START;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        ST_START: begin
          if (w_cnt_zero) begin
            r_cnt    <= WD_LOAD;
            r_clk_oe <= 1'b0;           // hand the clock to the device; data stays low
            r_state  <= ST_SEND;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        ST_SEND: begin
          if (w_fe) begin
            r_cnt    <= WD_LOAD;
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == LAST_DATA_EDGE) begin
              // Tenth edge: release data so the device sees the stop bit (1).
              r_dat_oe <= 1'b0;
              r_state  <= ST_ACK;
            end else begin
              r_dat_oe <= ~r_shift[0];
              r_shift  <= {1'b0, r_shift[8:1]};
            end
          end else if (w_cnt_zero) begin
            r_clk_oe           <= 1'b0;
            r_dat_oe           <= 1'b0;
            r_err[ERR_TIMEOUT] <= 1'b1;
            r_state            <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        // Device pulls data low around its eleventh falling edge to acknowledge.
        ST_ACK: begin
          if (w_fe) begin
            r_cnt            <= WD_LOAD;
            r_err[ERR_NOACK] <= w_dat_s;
            r_state          <= ST_WAIT_IDLE;
          end else if (w_cnt_zero) begin
            r_clk_oe           <= 1'b0;
            r_dat_oe           <= 1'b0;
            r_err[ERR_TIMEOUT] <= 1'b1;
            r_state            <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        ST_WAIT_IDLE: begin
          if (w_clk_s && w_dat_s) begin
            r_state <= ST_DONE;
          end else if (w_fe) begin
            r_cnt <= WD_LOAD;
          end else if (w_cnt_zero) begin
            r_clk_oe           <= 1'b0;
            r_dat_oe           <= 1'b0;
            r_err[ERR_TIMEOUT] <= 1'b1;
            r_state            <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  // All status outputs are decodes of registered state, so they are glitch-free
  // and tx_done / tx_err change on the same edge.
  assign o_tx_busy    = (r_state != ST_IDLE);
  assign o_tx_done    = (r_state == ST_DONE);
  assign o_tx_err     = (r_state == ST_DONE) ? r_err : 2'b00;
  assign o_rx_inhibit = o_tx_busy;
  assign o_ps2_clk_oe = r_clk_oe;
  assign o_ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a behavioural PS/2 device.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int STC  = 2;
  localparam int TO   = 400;
  localparam int HALF = 10;   // device clock half period in system cycles

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy, done, rx_inh;
  logic [1:0] err;
  logic       clk_oe, dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_line;
  logic       ps2_dat_line;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [1:0] last_err = 2'b00;
  logic [1:0] oe_at_done = 2'b00;

  always #5 clk = ~clk;

  // Open-drain wired-AND of host and device
  assign ps2_clk_line = ~(clk_oe | dev_clk_low);
  assign ps2_dat_line = ~(dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_CYCLES   (STC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk        (clk),
    .i_resetn     (resetn),
    .i_tx_data    (tx_data),
    .i_tx_start   (tx_start),
    .o_tx_busy    (busy),
    .o_tx_done    (done),
    .o_tx_err     (err),
    .o_rx_inhibit (rx_inh),
    .i_ps2_clk_in (ps2_clk_line),
    .i_ps2_dat_in (ps2_dat_line),
    .o_ps2_clk_oe (clk_oe),
    .o_ps2_dat_oe (dat_oe)
  );

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt   = done_cnt + 1;
      last_err   = err;
      oe_at_done = {clk_oe, dat_oe};
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation time limit reached, expected completion");
    $fatal(1, "global timeout");
  end

  // Reference: the 11-bit frame the device should see, index 0 first on the wire.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Behavioural keyboard: waits for request-to-send, clocks nedges falling edges,
  // samples data just before each fall, optionally ACKs on the eleventh edge.
  task automatic dev_frame(input bit ack, input int nedges,
                           output logic [10:0] bits, output bit ok);
    ok   = 1'b0;
    bits = '1;
    for (int i = 0; i < INH + STC + 50; i++) begin
      @(negedge clk);
      if (!clk_oe && dat_oe) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    repeat (5) @(negedge clk);
    for (int e = 0; e < nedges; e++) begin
      bits[e] = ps2_dat_line;
      if (e == 10 && ack) dev_dat_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_done_cnt(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_tx(input logic [7:0] b, input bit ack,
                        output logic [10:0] bits, output bit rts_ok, output bit done_ok);
    int c0;
    c0       = done_cnt;
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    dev_frame(ack, 11, bits, rts_ok);
    wait_done_cnt(c0 + 1, 200, done_ok);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    resetn   = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checks += 6;
    if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    if (err !== 2'b00)   begin errors++; $display("FAIL reset_err: got %b want 00", err); end
    if (rx_inh !== 1'b0) begin errors++; $display("FAIL reset_rx_inhibit: got %b want 0", rx_inh); end
    if (clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b want 0", clk_oe); end
    if (dat_oe !== 1'b0) begin errors++; $display("FAIL reset_dat_oe: got %b want 0", dat_oe); end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_accept_timing;
    int c0, n_clk, first_dat;
    logic [10:0] bits;
    bit ok, dok;
    c0 = done_cnt;
    tx_data  = CMD_RESET;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    checks += 4;
    if (busy !== 1'b1)   begin errors++; $display("FAIL accept_busy: got %b want 1", busy); end
    if (rx_inh !== 1'b1) begin errors++; $display("FAIL accept_rx_inhibit: got %b want 1", rx_inh); end
    if (clk_oe !== 1'b1) begin errors++; $display("FAIL accept_clk_oe: got %b want 1", clk_oe); end
    if (dat_oe !== 1'b0) begin errors++; $display("FAIL accept_dat_oe: got %b want 0", dat_oe); end
    n_clk = 0;
    first_dat = -1;
    for (int i = 0; i < INH + STC + 10; i++) begin
      if (clk_oe === 1'b1) n_clk++;
      if (dat_oe === 1'b1 && first_dat < 0) first_dat = i;
      @(negedge clk);
    end
    checks += 2;
    if (n_clk != INH + STC) begin errors++; $display("FAIL inhibit_len: got %0d want %0d", n_clk, INH + STC); end
    if (first_dat != INH)   begin errors++; $display("FAIL start_bit_pos: got %0d want %0d", first_dat, INH); end
    dev_frame(1'b1, 11, bits, ok);
    wait_done_cnt(c0 + 1, 200, dok);
    repeat (3) @(negedge clk);
    checks += 3;
    if (!ok || !dok) begin errors++; $display("FAIL accept_complete: rts %0d done %0d want 1 1", ok, dok); end
    if (bits !== frame_of(CMD_RESET)) begin errors++; $display("FAIL accept_frame: got %b want %b", bits, frame_of(CMD_RESET)); end
    if (last_err !== 2'b00) begin errors++; $display("FAIL accept_err: got %b want 00", last_err); end
  endtask

  task automatic test_frames;
    logic [7:0] vec [8];
    logic [10:0] bits, exp;
    bit rok, dok;
    vec[0] = CMD_SET_LEDS; vec[1] = 8'h00; vec[2] = 8'hFF; vec[3] = 8'h01;
    for (int i = 4; i < 8; i++) vec[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      exp = frame_of(vec[i]);
      run_tx(vec[i], 1'b1, bits, rok, dok);
      checks += 6;
      if (!rok) begin errors++; $display("FAIL frame_rts[%02h]: no request-to-send seen", vec[i]); end
      if (!dok) begin errors++; $display("FAIL frame_done[%02h]: no tx_done within budget", vec[i]); end
      if (bits !== exp) begin errors++; $display("FAIL frame_bits[%02h]: got %b want %b", vec[i], bits, exp); end
      if (bits[9] !== exp[9]) begin errors++; $display("FAIL frame_parity[%02h]: got %b want %b", vec[i], bits[9], exp[9]); end
      if (last_err !== 2'b00) begin errors++; $display("FAIL frame_err[%02h]: got %b want 00", vec[i], last_err); end
      if (oe_at_done !== 2'b00) begin errors++; $display("FAIL frame_oe[%02h]: got %b want 00", vec[i], oe_at_done); end
    end
  endtask

  task automatic test_timeout;
    int c0, elapsed;
    bit dok;
    c0 = done_cnt;
    tx_data  = 8'h5A;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    elapsed = 0;
    dok = 1'b0;
    for (int i = 0; i < INH + STC + TO + 60; i++) begin
      if (done_cnt > c0) begin dok = 1'b1; break; end
      @(negedge clk);
      elapsed++;
    end
    checks += 4;
    if (!dok) begin errors++; $display("FAIL timeout_done: no tx_done after %0d cycles", elapsed); end
    if (elapsed < INH + STC + TO - 2 || elapsed > INH + STC + TO + 4) begin
      errors++; $display("FAIL timeout_len: got %0d cycles want about %0d", elapsed, INH + STC + TO);
    end
    if (last_err !== 2'b01) begin errors++; $display("FAIL timeout_err: got %b want 01", last_err); end
    if (oe_at_done !== 2'b00) begin errors++; $display("FAIL timeout_oe: got %b want 00", oe_at_done); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_noack;
    logic [7:0] b;
    logic [10:0] bits;
    bit rok, dok;
    b = 8'($urandom);
    run_tx(b, 1'b0, bits, rok, dok);
    checks += 3;
    if (!rok || !dok) begin errors++; $display("FAIL noack_complete: rts %0d done %0d want 1 1", rok, dok); end
    if (bits !== frame_of(b)) begin errors++; $display("FAIL noack_bits: got %b want %b", bits, frame_of(b)); end
    if (last_err !== 2'b10) begin errors++; $display("FAIL noack_err: got %b want 10", last_err); end
  endtask

  task automatic test_reset_mid;
    int c0;
    logic [7:0] b;
    logic [10:0] bits, exp;
    bit rok, dok;
    b = 8'($urandom);
    exp = frame_of(b);
    c0 = done_cnt;
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    dev_frame(1'b1, 5, bits, rok);   // start + d0..d3 observed, d4 on the line
    resetn = 1'b0;
    @(negedge clk);
    checks += 5;
    if (bits[4:0] !== exp[4:0]) begin errors++; $display("FAIL midrst_partial: got %b want %b", bits[4:0], exp[4:0]); end
    if (clk_oe !== 1'b0) begin errors++; $display("FAIL midrst_clk_oe: got %b want 0", clk_oe); end
    if (dat_oe !== 1'b0) begin errors++; $display("FAIL midrst_dat_oe: got %b want 0", dat_oe); end
    if (busy !== 1'b0)   begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (done !== 1'b0)   begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    resetn = 1'b1;
    repeat (50) @(negedge clk);
    checks++;
    if (done_cnt != c0) begin errors++; $display("FAIL midrst_no_done: got %0d dones want %0d", done_cnt, c0); end
    b = 8'($urandom);
    run_tx(b, 1'b1, bits, rok, dok);
    checks += 2;
    if (!rok || !dok || bits !== frame_of(b)) begin
      errors++; $display("FAIL midrst_recover: bits %b want %b rts %0d done %0d", bits, frame_of(b), rok, dok);
    end
    if (last_err !== 2'b00) begin errors++; $display("FAIL midrst_recover_err: got %b want 00", last_err); end
  endtask

  task automatic test_busy_ignore;
    int c0;
    logic [7:0] a;
    logic [10:0] bits;
    bit rok, dok;
    a = 8'($urandom);
    c0 = done_cnt;
    tx_data  = a;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (5) @(negedge clk);
    tx_data  = ~a;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    dev_frame(1'b1, 11, bits, rok);
    wait_done_cnt(c0 + 1, 200, dok);
    repeat (60) @(negedge clk);
    checks += 4;
    if (!rok || !dok) begin errors++; $display("FAIL ignore_complete: rts %0d done %0d want 1 1", rok, dok); end
    if (bits !== frame_of(a)) begin errors++; $display("FAIL ignore_bits: got %b want %b", bits, frame_of(a)); end
    if (done_cnt != c0 + 1) begin errors++; $display("FAIL ignore_done_count: got %0d want %0d", done_cnt, c0 + 1); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int c0;
    logic [7:0] a, b;
    logic [10:0] bits_a, bits_b;
    bit rok_a, rok_b, dok, seen;
    a = 8'($urandom);
    b = 8'($urandom);
    c0 = done_cnt;
    tx_data  = a;
    tx_start = 1'b1;
    @(negedge clk);
    tx_data = b;              // held request, new byte: must not disturb the first frame
    dev_frame(1'b1, 11, bits_a, rok_a);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    checks += 2;
    if (!seen) begin errors++; $display("FAIL b2b_first_done: no tx_done within budget"); end
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_drop: got %b want 0", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept: got %b want 1", busy); end
    tx_start = 1'b0;
    dev_frame(1'b1, 11, bits_b, rok_b);
    wait_done_cnt(c0 + 2, 200, dok);
    repeat (3) @(negedge clk);
    checks += 4;
    if (!rok_a || !rok_b || !dok) begin errors++; $display("FAIL b2b_complete: rts %0d %0d done %0d want 1 1 1", rok_a, rok_b, dok); end
    if (bits_a !== frame_of(a)) begin errors++; $display("FAIL b2b_bits_a: got %b want %b", bits_a, frame_of(a)); end
    if (bits_b !== frame_of(b)) begin errors++; $display("FAIL b2b_bits_b: got %b want %b", bits_b, frame_of(b)); end
    if (last_err !== 2'b00) begin errors++; $display("FAIL b2b_err: got %b want 00", last_err); end
  endtask

  initial begin
    resetn   = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    test_reset();
    test_accept_timing();
    test_frames();
    test_timeout();
    test_noack();
    test_reset_mid();
    test_busy_ignore();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
